quire_normalize_4_0: RTL and testbench

// - Consumer end of the quire_4_0 output stream: takes the 19-bit two's-complement quire and its flags.
// - Converts the quire to normalized sign/scale/fraction form with guard and sticky bits.
// - Drives the downstream posit rounding/encoding stage.
// - Uses the same rts/rtr/sow/eow stream protocol on both sides.

---
 rtl/quire_normalize_4_0_pkg.sv | 39 +++
 rtl/quire_normalize_4_0_lzc.sv | 26 ++
 rtl/quire_normalize_4_0.sv | 255 +++++++++++++++++++++++++
 tb/tb_quire_normalize_4_0.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quire_normalize_4_0_pkg.sv
// Shared posit/quire sizing helpers and pipeline record types for the
// quire_4_0 normalizer.
//
// Contents:
//   get_quire_size         - quire width for a posit<nb,es> with 2^log_nb_accum headroom
//   get_quire_scale_width  - signed width able to hold any leading-one scale of that quire
//   QUIRE_BPP              - position of the 2^0 bit inside the quire
//   word_flags_t           - per-word side information carried down the pipeline
package quire_normalize_4_0_pkg;

    localparam int POSIT_WIDTH = 4;
    localparam int POSIT_ES    = 0;

    // Minimum quire holding the exact product of two posits
    // (useed^2 range on both sides of the binary point plus a sign bit).
    localparam int NQMIN = ((1 << (POSIT_ES + 2)) * (POSIT_WIDTH - 2)) + 1;

    // Bit index of weight 2^0: the fractional half of NQMIN without the sign.
    localparam int QUIRE_BPP = (NQMIN - 1) / 2;

    function automatic int get_quire_size(input int nb, input int es, input int log_nb_accum);
        return ((1 << (es + 2)) * (nb - 2)) + 1 + log_nb_accum;
    endfunction

    // Leading-one position ranges over the whole quire, so one bit more than
    // its index width covers every scale with sign.
    function automatic int get_quire_scale_width(input int nb, input int es, input int log_nb_accum);
        return $clog2(get_quire_size(nb, es, log_nb_accum)) + 1;
    endfunction

    typedef struct packed {
        logic sow;
        logic eow;
        logic sign;
        logic zero;
        logic nar;
    } word_flags_t;

endpackage

// File: rtl/quire_normalize_4_0_lzc.sv
// Combinational leading-zero counter.
//
// Ports:
//   data   in   WIDTH   value to scan, MSB first
//   count  out  CW      number of zeros above the leading one; WIDTH when data is 0
module quire_normalize_4_0_lzc #(
    parameter  int WIDTH = 19,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count
);

    // NOTE: count gets its all-zero value before the scan so every path
    // through the block assigns it and no latch is inferred.
    always_comb begin
        count = CW'(WIDTH);
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/quire_normalize_4_0.sv
// Quire normalizer: takes the two's-complement quire stream from quire_4_0 and
// emits sign / scale / fraction / guard / sticky for the posit rounding stage.
// Three pipeline stages (magnitude, leading-zero shift, field split) behind a
// one-entry skid latch, rts/rtr/sow/eow handshake on both sides.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rts_i / rtr_o        upstream valid / registered ready
//   sow_i, eow_i         window markers of the incoming word
//   data_i               quire, binary point between bits 4 and 3
//   sign_i               informational copy of data_i MSB (not used)
//   zero_i, NaR_i        quire flags
//   rtr_i / rts_o        downstream ready / output valid
//   sow_o, eow_o         window markers travelling with the word
//   fraction_o           FRAC_OUT bits below the leading one
//   scale_o              signed leading-one position relative to 2^0
//   guard_o, sticky_o    first dropped bit, OR of the rest
//   sign_o, zero_o, NaR_o  result classification
module quire_normalize_4_0
    import quire_normalize_4_0_pkg::*;
#(
    parameter  int LOG_NB_ACCUM = 10,
    parameter  int FRAC_OUT     = 4,
    parameter  bit EOW_ONLY     = 1'b1,
    localparam int QUIRE_SIZE   = get_quire_size(POSIT_WIDTH, POSIT_ES, LOG_NB_ACCUM),
    localparam int SCALE_W      = get_quire_scale_width(POSIT_WIDTH, POSIT_ES, LOG_NB_ACCUM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rts_i,
    output logic                      rtr_o,
    input  logic                      sow_i,
    input  logic                      eow_i,
    input  logic [QUIRE_SIZE-1:0]     data_i,
    input  logic                      sign_i,
    input  logic                      zero_i,
    input  logic                      NaR_i,
    input  logic                      rtr_i,
    output logic                      rts_o,
    output logic                      sow_o,
    output logic                      eow_o,
    output logic [FRAC_OUT-1:0]       fraction_o,
    output logic signed [SCALE_W-1:0] scale_o,
    output logic                      guard_o,
    output logic                      sticky_o,
    output logic                      sign_o,
    output logic                      zero_o,
    output logic                      NaR_o
);

    localparam int NORM_W = QUIRE_SIZE - 1;   // normalized bits below the leading one

    // data_i MSB is the authoritative sign; sign_i is deliberately ignored.
    logic sign_unused;
    assign sign_unused = sign_i;

    // ---------------------------------------------------------------- handshake
    logic process_en;
    logic receive_en;
    logic stage_en0;
    logic pass_word;

    assign process_en = rtr_i | ~rts_o;
    assign receive_en = rts_i & rtr_o;

    // rtr_o is one cycle late, so a word can arrive in the cycle the pipe
    // stalls; the skid latch catches exactly that one word.
    logic                  latched;
    logic [QUIRE_SIZE-1:0] skid_data;
    logic                  skid_sow;
    logic                  skid_eow;
    logic                  skid_zero;
    logic                  skid_nar;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtr_o     <= 1'b0;
            latched   <= 1'b0;
            skid_data <= '0;
            skid_sow  <= 1'b0;
            skid_eow  <= 1'b0;
            skid_zero <= 1'b0;
            skid_nar  <= 1'b0;
        end else begin
            rtr_o <= process_en;
            if (process_en) begin
                latched <= 1'b0;
            end else if (receive_en) begin
                latched   <= 1'b1;
                skid_data <= data_i;
                skid_sow  <= sow_i;
                skid_eow  <= eow_i;
                skid_zero <= zero_i;
                skid_nar  <= NaR_i;
            end
        end
    end

    // Latched word has priority: it arrived before whatever is on the inputs.
    logic [QUIRE_SIZE-1:0] in_data;
    logic                  in_sow;
    logic                  in_eow;
    logic                  in_zero;
    logic                  in_nar;
    logic [QUIRE_SIZE-1:0] in_mag;

    assign in_data = latched ? skid_data : data_i;
    assign in_sow  = latched ? skid_sow  : sow_i;
    assign in_eow  = latched ? skid_eow  : eow_i;
    assign in_zero = latched ? skid_zero : zero_i;
    assign in_nar  = latched ? skid_nar  : NaR_i;

    // Unsigned QUIRE_SIZE-bit result: negating the most negative quire wraps
    // to 2^(QUIRE_SIZE-1), which is exactly its magnitude.
    assign in_mag = in_data[QUIRE_SIZE-1] ? -in_data : in_data;

    assign stage_en0 = process_en & (receive_en | latched);
    // Filtered words are still consumed; they simply never occupy stage 1.
    assign pass_word = stage_en0 & (~EOW_ONLY | in_eow);

    // ---------------------------------------------------------------- stage 1
    logic                  s1_staged;
    word_flags_t           s1_flags;
    logic [QUIRE_SIZE-1:0] s1_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_staged <= 1'b0;
            s1_flags  <= '0;
            s1_mag    <= '0;
        end else if (process_en) begin
            s1_staged <= pass_word;
            if (pass_word) begin
                s1_flags <= '{sow:  in_sow,
                              eow:  in_eow,
                              sign: in_data[QUIRE_SIZE-1],
                              zero: in_zero | (in_mag == '0),
                              nar:  in_nar};
                s1_mag   <= in_mag;
            end else begin
                s1_flags <= '0;
                s1_mag   <= '0;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [SCALE_W-1:0]        lzc_count;
    logic [NORM_W-1:0]         norm_nxt;
    logic signed [SCALE_W-1:0] scale_nxt;

    quire_normalize_4_0_lzc #(
        .WIDTH (QUIRE_SIZE)
    ) u_lzc (
        .data  (s1_mag),
        .count (lzc_count)
    );

    // The leading one lands in the MSB and is dropped (hidden bit), so only
    // the bits below it need shifting.
    assign norm_nxt  = s1_mag[NORM_W-1:0] << lzc_count;
    assign scale_nxt = SCALE_W'(QUIRE_SIZE - 1 - QUIRE_BPP) - SCALE_W'(lzc_count);

    logic                      s2_staged;
    word_flags_t               s2_flags;
    logic [NORM_W-1:0]         s2_norm;
    logic signed [SCALE_W-1:0] s2_scale;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_staged <= 1'b0;
            s2_flags  <= '0;
            s2_norm   <= '0;
            s2_scale  <= '0;
        end else if (process_en) begin
            s2_staged <= s1_staged;
            if (s1_staged) begin
                s2_flags <= s1_flags;
                s2_norm  <= norm_nxt;
                s2_scale <= scale_nxt;
            end else begin
                s2_flags <= '0;
                s2_norm  <= '0;
                s2_scale <= '0;
            end
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic                      sign_nxt;
    logic                      zero_nxt;
    logic                      nar_nxt;
    logic signed [SCALE_W-1:0] scale_o_nxt;
    logic [FRAC_OUT-1:0]       frac_nxt;
    logic                      guard_nxt;
    logic                      sticky_nxt;

    // NaR outranks zero; both suppress every numeric field.
    always_comb begin
        sign_nxt    = 1'b0;
        zero_nxt    = 1'b0;
        nar_nxt     = 1'b0;
        scale_o_nxt = '0;
        frac_nxt    = '0;
        guard_nxt   = 1'b0;
        sticky_nxt  = 1'b0;
        if (s2_staged) begin
            if (s2_flags.nar) begin
                nar_nxt = 1'b1;
            end else if (s2_flags.zero) begin
                zero_nxt = 1'b1;
            end else begin
                sign_nxt    = s2_flags.sign;
                scale_o_nxt = s2_scale;
                frac_nxt    = s2_norm[NORM_W-1 -: FRAC_OUT];
                guard_nxt   = s2_norm[NORM_W-1-FRAC_OUT];
                sticky_nxt  = |s2_norm[NORM_W-2-FRAC_OUT:0];
            end
        end
    end

    logic s3_staged;

    // Outputs only move with process_en, which holds them under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_staged  <= 1'b0;
            sow_o      <= 1'b0;
            eow_o      <= 1'b0;
            sign_o     <= 1'b0;
            zero_o     <= 1'b0;
            NaR_o      <= 1'b0;
            scale_o    <= '0;
            fraction_o <= '0;
            guard_o    <= 1'b0;
            sticky_o   <= 1'b0;
        end else if (process_en) begin
            s3_staged  <= s2_staged;
            sow_o      <= s2_flags.sow;
            eow_o      <= s2_flags.eow;
            sign_o     <= sign_nxt;
            zero_o     <= zero_nxt;
            NaR_o      <= nar_nxt;
            scale_o    <= scale_o_nxt;
            fraction_o <= frac_nxt;
            guard_o    <= guard_nxt;
            sticky_o   <= sticky_nxt;
        end
    end

    assign rts_o = s3_staged;

endmodule

// File: tb/tb_quire_normalize_4_0.sv
// Directed bench for quire_normalize_4_0: a table of hand-computed vectors
// applied one at a time, then streaming with random back-pressure, the
// end-of-window filter and a mid-flight reset.
module tb_quire_normalize_4_0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rts_i;
    logic              rtr_o;
    logic              sow_i;
    logic              eow_i;
    logic [18:0]       data_i;
    logic              sign_i;
    logic              zero_i;
    logic              NaR_i;
    logic              rtr_i;
    logic              rts_o;
    logic              sow_o;
    logic              eow_o;
    logic [3:0]        fraction_o;
    logic signed [5:0] scale_o;
    logic              guard_o;
    logic              sticky_o;
    logic              sign_o;
    logic              zero_o;
    logic              NaR_o;

    always #5 clk = ~clk;

    quire_normalize_4_0 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rts_i      (rts_i),
        .rtr_o      (rtr_o),
        .sow_i      (sow_i),
        .eow_i      (eow_i),
        .data_i     (data_i),
        .sign_i     (sign_i),
        .zero_i     (zero_i),
        .NaR_i      (NaR_i),
        .rtr_i      (rtr_i),
        .rts_o      (rts_o),
        .sow_o      (sow_o),
        .eow_o      (eow_o),
        .fraction_o (fraction_o),
        .scale_o    (scale_o),
        .guard_o    (guard_o),
        .sticky_o   (sticky_o),
        .sign_o     (sign_o),
        .zero_o     (zero_o),
        .NaR_o      (NaR_o)
    );

    typedef struct {
        logic [18:0]       data;
        logic              zero;
        logic              nar;
        logic              e_sign;
        logic signed [5:0] e_scale;
        logic [3:0]        e_frac;
        logic              e_guard;
        logic              e_sticky;
        logic              e_zero;
        logic              e_nar;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] cur_num;
    logic [16:0] cur_out;
    assign cur_num = {NaR_o, zero_o, sign_o, scale_o, fraction_o, guard_o, sticky_o};
    assign cur_out = {sow_o, eow_o, cur_num};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] pack_exp(input vec_t v);
        return {v.e_nar, v.e_zero, v.e_sign, v.e_scale, v.e_frac, v.e_guard, v.e_sticky};
    endfunction

    task automatic drive(input vec_t v, input logic sow, input logic eow);
        rts_i  = 1'b1;
        data_i = v.data;
        sign_i = v.data[18];
        zero_i = v.zero;
        NaR_i  = v.nar;
        sow_i  = sow;
        eow_i  = eow;
    endtask

    task automatic idle_inputs();
        rts_i  = 1'b0;
        sow_i  = 1'b0;
        eow_i  = 1'b0;
        data_i = '0;
        sign_i = 1'b0;
        zero_i = 1'b0;
        NaR_i  = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the word is taken.
    task automatic send_one(input vec_t v, input logic sow, input logic eow, input string tag);
        int cnt = 0;
        drive(v, sow, eow);
        while (!rtr_o && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) check({tag, "_accept_timeout"}, 32'(rtr_o), 32'(1));
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic apply_vec(input int i);
        int   cnt = 0;
        vec_t v   = vecs[i];
        string tg = $sformatf("vec%0d", i);
        send_one(v, 1'b1, 1'b1, tg);
        while (!rts_o && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check({tg, "_valid"},  32'(rts_o),      32'(1));
        check({tg, "_nar"},    32'(NaR_o),      32'(v.e_nar));
        check({tg, "_zero"},   32'(zero_o),     32'(v.e_zero));
        check({tg, "_sign"},   32'(sign_o),     32'(v.e_sign));
        check({tg, "_scale"},  32'(scale_o),    32'(v.e_scale));
        check({tg, "_frac"},   32'(fraction_o), 32'(v.e_frac));
        check({tg, "_guard"},  32'(guard_o),    32'(v.e_guard));
        check({tg, "_sticky"}, 32'(sticky_o),   32'(v.e_sticky));
        check({tg, "_sow"},    32'(sow_o),      32'(1));
        check({tg, "_eow"},    32'(eow_o),      32'(1));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          data      zero  nar   sign  scale   frac     guard sticky ezero enar
        vecs[0]  = '{19'h00010, 1'b0, 1'b0, 1'b0, 6'sd0,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{19'h7FFE8, 1'b0, 1'b0, 1'b1, 6'sd0,  4'b1000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{19'h0007F, 1'b0, 1'b0, 1'b0, 6'sd2,  4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{19'h00001, 1'b0, 1'b0, 1'b0, -6'sd4, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{19'h40000, 1'b0, 1'b0, 1'b1, 6'sd14, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{19'h00123, 1'b1, 1'b0, 1'b0, 6'sd0,  4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{19'h7FFFF, 1'b1, 1'b1, 1'b0, 6'sd0,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{19'h00000, 1'b0, 1'b0, 1'b0, 6'sd0,  4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{19'h3FFFF, 1'b0, 1'b0, 1'b0, 6'sd13, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{19'h7FFFF, 1'b0, 1'b0, 1'b1, -6'sd4, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{19'h00058, 1'b0, 1'b0, 1'b0, 6'sd2,  4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{19'h00042, 1'b0, 1'b0, 1'b0, 6'sd2,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{19'h00041, 1'b0, 1'b0, 1'b0, 6'sd2,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{19'h00120, 1'b0, 1'b0, 1'b0, 6'sd4,  4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{19'h7FF00, 1'b0, 1'b0, 1'b1, 6'sd4,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{19'h7FFBF, 1'b0, 1'b0, 1'b1, 6'sd2,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};

        // ---------------- reset state
        rst_n = 1'b0;
        rtr_i = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("reset_rts", 32'(rts_o),   32'(0));
        check("reset_rtr", 32'(rtr_o),   32'(0));
        check("reset_out", 32'(cur_out), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rtr_after_reset", 32'(rtr_o), 32'(1));

        // ---------------- directed table
        for (int i = 0; i < NVEC; i++) begin
            apply_vec(i);
        end

        // ---------------- streaming with random back-pressure
        begin
            int   sent = 0;
            int   rcvd = 0;
            int   cyc  = 0;
            logic prev_hold = 1'b0;
            logic [16:0] prev_out = '0;
            while (rcvd < 8 && cyc < 400) begin
                if (prev_hold) begin
                    check("stream_rtr_drop", 32'(rtr_o),   32'(0));
                    check("stream_hold",     32'(cur_out), 32'(prev_out));
                end
                rtr_i = 1'($urandom_range(0, 1));
                if (rts_o && rtr_i) begin
                    check($sformatf("stream_word%0d", rcvd), 32'(cur_out),
                          32'({2'b11, pack_exp(vecs[rcvd])}));
                    rcvd++;
                end
                prev_hold = rts_o & ~rtr_i;
                prev_out  = cur_out;
                if (sent < 8) begin
                    drive(vecs[sent], 1'b1, 1'b1);
                    if (rtr_o) sent++;
                end else begin
                    idle_inputs();
                end
                @(negedge clk);
                cyc++;
            end
            check("stream_count", 32'(rcvd), 32'(8));
            idle_inputs();
            rtr_i = 1'b1;
            repeat (5) @(negedge clk);
            check("stream_no_extra", 32'(rts_o), 32'(0));
        end

        // ---------------- end-of-window filter
        begin
            int          n_out = 0;
            logic [16:0] got   = '0;
            rtr_i = 1'b1;
            send_one(vecs[0], 1'b1, 1'b0, "win0");
            send_one(vecs[3], 1'b0, 1'b0, "win1");
            send_one(vecs[4], 1'b0, 1'b0, "win2");
            send_one(vecs[2], 1'b0, 1'b1, "win3");
            for (int c = 0; c < 10; c++) begin
                if (rts_o) begin
                    n_out++;
                    got = cur_out;
                end
                @(negedge clk);
            end
            check("window_count", 32'(n_out), 32'(1));
            check("window_word",  32'(got),   32'({2'b01, pack_exp(vecs[2])}));
        end

        // ---------------- reset with words in flight
        begin
            int n_out = 0;
            rtr_i = 1'b1;
            drive(vecs[0], 1'b1, 1'b1);
            @(negedge clk);
            drive(vecs[1], 1'b1, 1'b1);
            @(negedge clk);
            drive(vecs[2], 1'b1, 1'b1);
            @(negedge clk);
            idle_inputs();
            check("flight_rts", 32'(rts_o), 32'(1));
            rst_n = 1'b0;
            #1;
            check("flight_reset_async", 32'(rts_o), 32'(0));
            @(negedge clk);
            check("flight_reset_rts", 32'(rts_o),   32'(0));
            check("flight_reset_rtr", 32'(rtr_o),   32'(0));
            check("flight_reset_out", 32'(cur_out), 32'(0));
            rst_n = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (rts_o) n_out++;
            end
            check("flight_no_stale", 32'(n_out), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
